// File: rtl/sym2x2_inverse_fx_if.sv
// ---------------------------------------------------------------------------
// sym2x2_inverse_fx_if
// Start/done handshake and data bundle for the symmetric 2x2 inverse stage.
//   start            : request a new inversion (driven by master)
//   a11, a12, a22    : signed Q(W-FRAC).FRAC matrix elements (driven by master)
//   busy             : operation in progress (driven by slave)
//   finished         : one-cycle "results valid" pulse (driven by slave)
//   singular, ovf    : status of the last operation (driven by slave)
//   inv11/inv12/inv22: signed inverse elements (driven by slave)
// ---------------------------------------------------------------------------
interface sym2x2_inverse_fx_if #(
    parameter int W = 32
);
    logic         start;
    logic [W-1:0] a11;
    logic [W-1:0] a12;
    logic [W-1:0] a22;
    logic         busy;
    logic         finished;
    logic         singular;
    logic         ovf;
    logic [W-1:0] inv11;
    logic [W-1:0] inv12;
    logic [W-1:0] inv22;

    modport master (
        output start, a11, a12, a22,
        input  busy, finished, singular, ovf, inv11, inv12, inv22
    );

    modport slave (
        input  start, a11, a12, a22,
        output busy, finished, singular, ovf, inv11, inv12, inv22
    );
endinterface

// File: rtl/sym2x2_inverse_fx.sv
// ---------------------------------------------------------------------------
// sym2x2_inverse_fx
// Iterative fixed-point inverse of XtX = [a11 a12; a12 a22].
// det is formed in one cycle, 1/|det| is produced by a restoring divider
// (one quotient bit per cycle, DW cycles), then the three cofactors are scaled
// by that reciprocal in one cycle with truncation and saturation.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset (aborts any operation silently)
//   bus   : slave side of sym2x2_inverse_fx_if (start/data in, status/results out)
// ---------------------------------------------------------------------------
module sym2x2_inverse_fx #(
    parameter int W    = 32,
    parameter int FRAC = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    sym2x2_inverse_fx_if.slave     bus
);
    localparam int DW   = 4 * FRAC + 1;     // quotient bits == divider iterations
    localparam int CW   = $clog2(DW);
    localparam int DETW = 2 * W + 1;        // full-width determinant
    localparam int PRW  = W + DW;           // |cofactor| * R product width

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DIV   = 2'd2,
        S_SCALE = 2'd3
    } state_t;

    // Magnitude of a two's complement word; -2^(W-1) maps to 2^(W-1) unsigned.
    function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
        return v[W-1] ? (~v + {{(W-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Drop the 2*FRAC fraction bits of the product, apply the sign, clamp.
    // Returns {clamped, result}.
    function automatic logic [W:0] sat_scale(input logic [PRW-1:0] prod, input logic neg);
        logic [PRW-1:0] mag;
        logic [PRW-1:0] pos_max;
        logic [PRW-1:0] neg_max;
        mag     = prod >> (2 * FRAC);
        pos_max = {{(PRW-W+1){1'b0}}, {(W-1){1'b1}}};
        neg_max = pos_max + {{(PRW-1){1'b0}}, 1'b1};
        if (neg) begin
            if (mag > neg_max) begin
                return {1'b1, 1'b1, {(W-1){1'b0}}};
            end else begin
                return {1'b0, (~mag[W-1:0] + {{(W-1){1'b0}}, 1'b1})};
            end
        end else begin
            if (mag > pos_max) begin
                return {1'b1, 1'b0, {(W-1){1'b1}}};
            end else begin
                return {1'b0, mag[W-1:0]};
            end
        end
    endfunction

    state_t            state_q;
    logic              busy_q, finished_q, singular_q, ovf_q;
    logic [W-1:0]      inv11_q, inv12_q, inv22_q;
    logic [W-1:0]      a11_q, a12_q, a22_q;
    logic [W-1:0]      mag11_q, mag12_q, mag22_q;     // |a22|, |a12|, |a11|
    logic              neg11_q, neg12_q, neg22_q;     // final result signs
    logic [DETW-1:0]   det_mag_q;
    logic [DETW-1:0]   rem_q;
    logic [DW-1:0]     q_q;
    logic [CW-1:0]     cnt_q;

    logic signed [DETW-1:0] p1_s, p2_s, det_s;
    logic [DETW-1:0]        det_abs_s;
    logic [DETW:0]          rem_sh_s, den_x_s;
    logic [DETW-1:0]        diff_s;
    logic                   ge_s;
    logic [PRW-1:0]         prod11_s, prod12_s, prod22_s;
    logic [W:0]             res11_s, res12_s, res22_s;

    // Determinant, exact at 2W+1 bits with 2*FRAC fraction bits.
    assign p1_s      = DETW'($signed(a11_q)) * DETW'($signed(a22_q));
    assign p2_s      = DETW'($signed(a12_q)) * DETW'($signed(a12_q));
    assign det_s     = p1_s - p2_s;
    assign det_abs_s = det_s[DETW-1] ? DETW'(-det_s) : DETW'(det_s);

    // Restoring divider step: dividend 2^(4*FRAC) has its only set bit first.
    assign rem_sh_s = {rem_q, (cnt_q == {CW{1'b0}})};
    assign den_x_s  = {1'b0, det_mag_q};
    assign ge_s     = (rem_sh_s >= den_x_s);
    assign diff_s   = DETW'(rem_sh_s - den_x_s);

    // Cofactor scaling by the reciprocal R held in q_q.
    assign prod11_s = PRW'(mag11_q) * PRW'(q_q);
    assign prod12_s = PRW'(mag12_q) * PRW'(q_q);
    assign prod22_s = PRW'(mag22_q) * PRW'(q_q);
    assign res11_s  = sat_scale(prod11_s, neg11_q);
    assign res12_s  = sat_scale(prod12_s, neg12_q);
    assign res22_s  = sat_scale(prod22_s, neg22_q);

    // Control FSM, divider datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            singular_q <= 1'b0;
            ovf_q      <= 1'b0;
            inv11_q    <= {W{1'b0}};
            inv12_q    <= {W{1'b0}};
            inv22_q    <= {W{1'b0}};
            a11_q      <= {W{1'b0}};
            a12_q      <= {W{1'b0}};
            a22_q      <= {W{1'b0}};
            mag11_q    <= {W{1'b0}};
            mag12_q    <= {W{1'b0}};
            mag22_q    <= {W{1'b0}};
            neg11_q    <= 1'b0;
            neg12_q    <= 1'b0;
            neg22_q    <= 1'b0;
            det_mag_q  <= {DETW{1'b0}};
            rem_q      <= {DETW{1'b0}};
            q_q        <= {DW{1'b0}};
            cnt_q      <= {CW{1'b0}};
        end else begin
            finished_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a11_q      <= bus.a11;
                        a12_q      <= bus.a12;
                        a22_q      <= bus.a22;
                        singular_q <= 1'b0;
                        ovf_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_MUL;
                    end else begin
                        state_q    <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (det_s == {DETW{1'b0}}) begin
                        singular_q <= 1'b1;
                        inv11_q    <= {W{1'b0}};
                        inv12_q    <= {W{1'b0}};
                        inv22_q    <= {W{1'b0}};
                        finished_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        det_mag_q  <= det_abs_s;
                        mag11_q    <= abs_w(a22_q);
                        mag12_q    <= abs_w(a12_q);
                        mag22_q    <= abs_w(a11_q);
                        // inv12 carries the cofactor's extra negation.
                        neg11_q    <= a22_q[W-1] ^ det_s[DETW-1];
                        neg12_q    <= ~(a12_q[W-1] ^ det_s[DETW-1]);
                        neg22_q    <= a11_q[W-1] ^ det_s[DETW-1];
                        rem_q      <= {DETW{1'b0}};
                        q_q        <= {DW{1'b0}};
                        cnt_q      <= {CW{1'b0}};
                        state_q    <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= ge_s ? diff_s : rem_sh_s[DETW-1:0];
                    q_q   <= {q_q[DW-2:0], ge_s};
                    cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(DW - 1)) begin
                        state_q <= S_SCALE;
                    end else begin
                        state_q <= S_DIV;
                    end
                end
                S_SCALE: begin
                    inv11_q    <= res11_s[W-1:0];
                    inv12_q    <= res12_s[W-1:0];
                    inv22_q    <= res22_s[W-1:0];
                    ovf_q      <= res11_s[W] | res12_s[W] | res22_s[W];
                    finished_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.finished = finished_q;
    assign bus.singular = singular_q;
    assign bus.ovf      = ovf_q;
    assign bus.inv11    = inv11_q;
    assign bus.inv12    = inv12_q;
    assign bus.inv22    = inv22_q;
endmodule

// File: tb/tb_sym2x2_inverse_fx.sv
// ---------------------------------------------------------------------------
// tb_sym2x2_inverse_fx
// Directed-vector bench for sym2x2_inverse_fx (W=32, FRAC=12, 49 divider
// cycles). Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sym2x2_inverse_fx;
    localparam int W = 32;
    localparam int LAT = 51;      // accept edge -> finished edge for FRAC=12

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   lat;

    sym2x2_inverse_fx_if #(.W(W)) ifc ();

    sym2x2_inverse_fx #(.W(W), .FRAC(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts an operation from a falling edge; returns at the falling edge where
    // finished is seen (or after 100 cycles). lat counts rising edges after the
    // accepting edge.
    task automatic run_op(input logic [W-1:0] a11, input logic [W-1:0] a12,
                          input logic [W-1:0] a22, output int latency);
        ifc.start = 1'b1;
        ifc.a11   = a11;
        ifc.a12   = a12;
        ifc.a22   = a22;
        @(posedge clk);
        latency = 0;
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.a11   = 32'd0;
        ifc.a12   = 32'd0;
        ifc.a22   = 32'd0;
        while (ifc.finished !== 1'b1 && latency < 100) begin
            @(posedge clk);
            latency++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifc.start = 1'b0;
        ifc.a11 = 32'd0;
        ifc.a12 = 32'd0;
        ifc.a22 = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        vectors++; if (ifc.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b exp 0", ifc.busy); end
        vectors++; if (ifc.finished !== 1'b0) begin miscompares++; $display("FAIL reset_finished: got %b exp 0", ifc.finished); end
        vectors++; if (ifc.singular !== 1'b0) begin miscompares++; $display("FAIL reset_singular: got %b exp 0", ifc.singular); end
        vectors++; if (ifc.ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b exp 0", ifc.ovf); end
        vectors++; if ({ifc.inv11, ifc.inv12, ifc.inv22} !== 96'd0) begin miscompares++; $display("FAIL reset_inv: got %h exp 0", {ifc.inv11, ifc.inv12, ifc.inv22}); end
    endtask

    task automatic test_identity();
        ifc.start = 1'b1;
        ifc.a11 = 32'sd4096;
        ifc.a12 = 32'sd0;
        ifc.a22 = 32'sd4096;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        vectors++; if (ifc.busy !== 1'b1) begin miscompares++; $display("FAIL ident_busy_after_accept: got %b exp 1", ifc.busy); end
        lat = 0;
        while (ifc.finished !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL ident_latency: got %0d exp %0d", lat, LAT); end
        vectors++; if ($signed(ifc.inv11) !== 32'sd4096) begin miscompares++; $display("FAIL ident_inv11: got %0d exp 4096", $signed(ifc.inv11)); end
        vectors++; if ($signed(ifc.inv12) !== 32'sd0) begin miscompares++; $display("FAIL ident_inv12: got %0d exp 0", $signed(ifc.inv12)); end
        vectors++; if ($signed(ifc.inv22) !== 32'sd4096) begin miscompares++; $display("FAIL ident_inv22: got %0d exp 4096", $signed(ifc.inv22)); end
        vectors++; if ({ifc.singular, ifc.ovf, ifc.busy} !== 3'b000) begin miscompares++; $display("FAIL ident_flags: got %b exp 000", {ifc.singular, ifc.ovf, ifc.busy}); end
        @(negedge clk);
        vectors++; if (ifc.finished !== 1'b0) begin miscompares++; $display("FAIL ident_finished_width: got %b exp 0", ifc.finished); end
        vectors++; if ($signed(ifc.inv11) !== 32'sd4096) begin miscompares++; $display("FAIL ident_hold_inv11: got %0d exp 4096", $signed(ifc.inv11)); end
    endtask

    task automatic test_det3();
        run_op(32'sd8192, 32'sd4096, 32'sd8192, lat);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL det3_latency: got %0d exp %0d", lat, LAT); end
        vectors++; if ($signed(ifc.inv11) !== 32'sd2730) begin miscompares++; $display("FAIL det3_inv11: got %0d exp 2730", $signed(ifc.inv11)); end
        vectors++; if ($signed(ifc.inv12) !== -32'sd1365) begin miscompares++; $display("FAIL det3_inv12: got %0d exp -1365", $signed(ifc.inv12)); end
        vectors++; if ($signed(ifc.inv22) !== 32'sd2730) begin miscompares++; $display("FAIL det3_inv22: got %0d exp 2730", $signed(ifc.inv22)); end
        vectors++; if ({ifc.singular, ifc.ovf} !== 2'b00) begin miscompares++; $display("FAIL det3_flags: got %b exp 00", {ifc.singular, ifc.ovf}); end
        @(negedge clk);
    endtask

    task automatic test_singular();
        // Previous outputs are non-zero, so the clear to zero is visible.
        run_op(32'sd4096, 32'sd4096, 32'sd4096, lat);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL sing_latency: got %0d exp 1", lat); end
        vectors++; if (ifc.singular !== 1'b1) begin miscompares++; $display("FAIL sing_flag: got %b exp 1", ifc.singular); end
        vectors++; if ({ifc.inv11, ifc.inv12, ifc.inv22} !== 96'd0) begin miscompares++; $display("FAIL sing_outputs: got %h exp 0", {ifc.inv11, ifc.inv12, ifc.inv22}); end
        vectors++; if (ifc.busy !== 1'b0) begin miscompares++; $display("FAIL sing_busy: got %b exp 0", ifc.busy); end
        @(negedge clk);
        vectors++; if ({ifc.finished, ifc.singular} !== 2'b01) begin miscompares++; $display("FAIL sing_hold: got %b exp 01", {ifc.finished, ifc.singular}); end
    endtask

    task automatic test_saturation();
        run_op(32'sd1048576, 32'sd1023, 32'sd1, lat);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL sat_latency: got %0d exp %0d", lat, LAT); end
        vectors++; if ($signed(ifc.inv22) !== 32'sd2147483647) begin miscompares++; $display("FAIL sat_inv22: got %0d exp 2147483647", $signed(ifc.inv22)); end
        vectors++; if ($signed(ifc.inv11) !== 32'sd8196) begin miscompares++; $display("FAIL sat_inv11: got %0d exp 8196", $signed(ifc.inv11)); end
        vectors++; if ($signed(ifc.inv12) !== -32'sd8384509) begin miscompares++; $display("FAIL sat_inv12: got %0d exp -8384509", $signed(ifc.inv12)); end
        vectors++; if ({ifc.singular, ifc.ovf} !== 2'b01) begin miscompares++; $display("FAIL sat_flags: got %b exp 01", {ifc.singular, ifc.ovf}); end
        @(negedge clk);
    endtask

    task automatic test_negative_det();
        // Also checks that the new start clears the held ovf flag.
        run_op(32'sd4096, 32'sd0, -32'sd4096, lat);
        vectors++; if ($signed(ifc.inv11) !== 32'sd4096) begin miscompares++; $display("FAIL neg_inv11: got %0d exp 4096", $signed(ifc.inv11)); end
        vectors++; if ($signed(ifc.inv12) !== 32'sd0) begin miscompares++; $display("FAIL neg_inv12: got %0d exp 0", $signed(ifc.inv12)); end
        vectors++; if ($signed(ifc.inv22) !== -32'sd4096) begin miscompares++; $display("FAIL neg_inv22: got %0d exp -4096", $signed(ifc.inv22)); end
        vectors++; if ({ifc.singular, ifc.ovf} !== 2'b00) begin miscompares++; $display("FAIL neg_flags: got %b exp 00", {ifc.singular, ifc.ovf}); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        ifc.start = 1'b1;
        ifc.a11 = 32'sd8192;
        ifc.a12 = 32'sd4096;
        ifc.a22 = 32'sd8192;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (10) @(negedge clk);
        // Identity request in the middle of the division must be dropped.
        ifc.start = 1'b1;
        ifc.a11 = 32'sd4096;
        ifc.a12 = 32'sd0;
        ifc.a22 = 32'sd4096;
        @(negedge clk);
        ifc.start = 1'b0;
        lat = 11;
        while (ifc.finished !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL busy_start_latency: got %0d exp %0d", lat, LAT); end
        vectors++; if ($signed(ifc.inv11) !== 32'sd2730) begin miscompares++; $display("FAIL busy_start_inv11: got %0d exp 2730", $signed(ifc.inv11)); end
        vectors++; if ($signed(ifc.inv12) !== -32'sd1365) begin miscompares++; $display("FAIL busy_start_inv12: got %0d exp -1365", $signed(ifc.inv12)); end
        @(negedge clk);
        vectors++; if (ifc.busy !== 1'b0) begin miscompares++; $display("FAIL busy_start_no_restart: got %b exp 0", ifc.busy); end
    endtask

    task automatic test_reset_mid_div();
        int pulses;
        ifc.start = 1'b1;
        ifc.a11 = 32'sd8192;
        ifc.a12 = 32'sd4096;
        ifc.a22 = 32'sd8192;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++; if ({ifc.busy, ifc.finished, ifc.singular, ifc.ovf} !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_flags: got %b exp 0000", {ifc.busy, ifc.finished, ifc.singular, ifc.ovf}); end
        vectors++; if ({ifc.inv11, ifc.inv12, ifc.inv22} !== 96'd0) begin miscompares++; $display("FAIL rst_mid_inv: got %h exp 0", {ifc.inv11, ifc.inv12, ifc.inv22}); end
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ifc.finished === 1'b1) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL rst_mid_no_finished: got %0d pulses exp 0", pulses); end
        run_op(32'sd4096, 32'sd0, 32'sd4096, lat);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL rst_fresh_latency: got %0d exp %0d", lat, LAT); end
        vectors++; if ({ifc.inv11, ifc.inv12, ifc.inv22} !== {32'd4096, 32'd0, 32'd4096}) begin miscompares++; $display("FAIL rst_fresh_inv: got %h exp identity", {ifc.inv11, ifc.inv12, ifc.inv22}); end
    endtask

    task automatic test_back_to_back();
        // Called while finished is high: the next start is accepted now.
        run_op(32'sd8192, 32'sd4096, 32'sd8192, lat);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL b2b_first_latency: got %0d exp %0d", lat, LAT); end
        run_op(32'sd4096, 32'sd0, -32'sd4096, lat);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL b2b_second_latency: got %0d exp %0d", lat, LAT); end
        vectors++; if ($signed(ifc.inv22) !== -32'sd4096) begin miscompares++; $display("FAIL b2b_inv22: got %0d exp -4096", $signed(ifc.inv22)); end
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        @(negedge clk);
        test_reset();
        test_identity();
        test_det3();
        test_singular();
        test_saturation();
        test_negative_det();
        test_start_while_busy();
        test_reset_mid_div();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
